// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button lines in, conditioned levels and event pulses out
interface button_conditioner_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] button_n;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] released;
    logic [WIDTH-1:0] repeated;
    logic [WIDTH-1:0] action;

    modport master (
        output button_n,
        input  held, pressed, released, repeated, action
    );

    modport slave (
        input  button_n,
        output held, pressed, released, repeated, action
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce, edge-detect and auto-repeat active-low buttons
module button_conditioner #(
    parameter int               WIDTH          = 3,
    parameter int               DEBOUNCE_TICKS = 2,
    parameter int               HOLD_TICKS     = 50,
    parameter int               REPEAT_TICKS   = 10,
    parameter logic [WIDTH-1:0] REPEAT_MASK    = '0
) (
    input logic                 clock,
    input logic                 reset_n,
    button_conditioner_if.slave bus
);
    localparam int DEB_W  = $clog2(DEBOUNCE_TICKS < 2 ? 2 : DEBOUNCE_TICKS);
    localparam int HOLD_W = $clog2(HOLD_TICKS < 2 ? 2 : HOLD_TICKS);
    localparam int REP_W  = $clog2(REPEAT_TICKS < 2 ? 2 : REPEAT_TICKS);
    localparam int CNT_W  = HOLD_W > REP_W ? HOLD_W : REP_W;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {RELEASED, HOLD_WAIT, REPEATING} state_t;

    logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0] held_q, held_d, pressed_q, pressed_d, released_q, released_d;
    logic [WIDTH-1:0] repeated_q, repeated_d, action_q, action_d;
    logic [DEB_W-1:0] deb_q [WIDTH];
    logic [DEB_W-1:0] deb_d [WIDTH];
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];

    // Per channel: debounce against the accepted level, then run the hold/repeat FSM;
    // a release always wins so no repeat can fire on the release edge.
    always_comb begin
        s1_d       = ~bus.button_n;
        s2_d       = s1_q;
        held_d     = held_q;
        pressed_d  = '0;
        released_d = '0;
        repeated_d = '0;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == held_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_LAST) begin
                deb_d[i]      = '0;
                held_d[i]     = s2_q[i];
                pressed_d[i]  = s2_q[i];
                released_d[i] = ~s2_q[i];
            end else begin
                deb_d[i] = deb_q[i] + 1'b1;
            end
            if (released_d[i]) begin
                state_d[i] = RELEASED;
                cnt_d[i]   = '0;
            end else if (pressed_d[i]) begin
                state_d[i] = HOLD_WAIT;
                cnt_d[i]   = '0;
            end else if (state_q[i] == HOLD_WAIT) begin
                if (cnt_q[i] != HOLD_LAST) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else if (REPEAT_MASK[i]) begin
                    repeated_d[i] = 1'b1;
                    cnt_d[i]      = '0;
                    state_d[i]    = REPEATING;
                end
            end else if (state_q[i] == REPEATING) begin
                if (cnt_q[i] != REP_LAST) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    repeated_d[i] = 1'b1;
                    cnt_d[i]      = '0;
                end
            end
        end
        action_d = pressed_d | repeated_d;
    end

    // Register all state and outputs; synchronous active-low reset clears everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            held_q     <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            repeated_q <= '0;
            action_q   <= '0;
            deb_q      <= '{default: '0};
            cnt_q      <= '{default: '0};
            state_q    <= '{default: RELEASED};
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            held_q     <= held_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            repeated_q <= repeated_d;
            action_q   <= action_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign bus.held     = held_q;
    assign bus.pressed  = pressed_q;
    assign bus.released = released_q;
    assign bus.repeated = repeated_q;
    assign bus.action   = action_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven and hand-sequenced checks of the button conditioner
module tb_button_conditioner;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    button_conditioner_if #(.WIDTH(3)) bus ();

    button_conditioner #(
        .WIDTH(3), .DEBOUNCE_TICKS(4), .HOLD_TICKS(5), .REPEAT_TICKS(3), .REPEAT_MASK(3'b001)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] bn;
        logic       rn;
        logic [2:0] held, pr, rl, rp, ac;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [2:0] bn, input logic rn, input logic [2:0] h, p, r, rp, a);
        tbl.push_back('{bn, rn, h, p, r, rp, a});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_press(input logic [2:0] m, input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus.pressed == 3'b000 && n < 12);
        chk({nm, "_latency"}, n, 6);
        chk({nm, "_mask"}, bus.pressed, m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.button_n = 3'b111;
        // reset rows
        add(3'b111, 0, 0, 0, 0, 0, 0);
        add(3'b111, 0, 0, 0, 0, 0, 0);
        // press channel 0: accepted after edge 5, one repeat at +5, release accepted 5 edges after raw release
        for (int k = 0; k < 5; k++) add(3'b110, 1, 0, 0, 0, 0, 0);
        add(3'b110, 1, 3'b001, 3'b001, 0, 0, 3'b001);
        add(3'b110, 1, 3'b001, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(3'b111, 1, 3'b001, 0, 0, 0, 0);
        add(3'b111, 1, 3'b001, 0, 0, 3'b001, 3'b001);
        add(3'b111, 1, 3'b001, 0, 0, 0, 0);
        add(3'b111, 1, 0, 0, 3'b001, 0, 0);
        for (int k = 0; k < 2; k++) add(3'b111, 1, 0, 0, 0, 0, 0);
        // 3-cycle glitch on channel 1 is ignored, then a 4-cycle low is accepted
        for (int k = 0; k < 3; k++) add(3'b101, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(3'b111, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(3'b101, 1, 0, 0, 0, 0, 0);
        add(3'b111, 1, 0, 0, 0, 0, 0);
        add(3'b111, 1, 3'b010, 3'b010, 0, 0, 3'b010);
        for (int k = 0; k < 3; k++) add(3'b111, 1, 3'b010, 0, 0, 0, 0);
        add(3'b111, 1, 0, 0, 3'b010, 0, 0);
        add(3'b111, 1, 0, 0, 0, 0, 0);
        // channels 0 and 2 pressed together
        for (int k = 0; k < 5; k++) add(3'b010, 1, 0, 0, 0, 0, 0);
        add(3'b010, 1, 3'b101, 3'b101, 0, 0, 3'b101);
        for (int k = 0; k < 4; k++) add(3'b111, 1, 3'b101, 0, 0, 0, 0);
        add(3'b111, 1, 3'b101, 0, 0, 3'b001, 3'b001);
        add(3'b111, 1, 0, 0, 3'b101, 0, 0);
        add(3'b111, 1, 0, 0, 0, 0, 0);

        foreach (tbl[r]) begin
            bus.button_n = tbl[r].bn;
            reset_n = tbl[r].rn;
            step();
            chk($sformatf("row%0d_held", r), bus.held, tbl[r].held);
            chk($sformatf("row%0d_pressed", r), bus.pressed, tbl[r].pr);
            chk($sformatf("row%0d_released", r), bus.released, tbl[r].rl);
            chk($sformatf("row%0d_repeated", r), bus.repeated, tbl[r].rp);
            chk($sformatf("row%0d_action", r), bus.action, tbl[r].ac);
        end

        // long hold on masked channel 0: repeats at +5, +8, ...; release raw at +21, accepted at +26
        bus.button_n = 3'b110;
        wait_press(3'b001, "t3_press");
        for (int off = 1; off <= 30; off++) begin
            logic [2:0] rp;
            if (off == 21) bus.button_n = 3'b111;
            step();
            rp = (off >= 5 && off < 26 && (off - 5) % 3 == 0) ? 3'b001 : 3'b000;
            chk($sformatf("t3_rep_%0d", off), bus.repeated, rp);
            chk($sformatf("t3_act_%0d", off), bus.action, rp);
            chk($sformatf("t3_rel_%0d", off), bus.released, off == 26 ? 3'b001 : 3'b000);
            chk($sformatf("t3_held_%0d", off), bus.held, off < 26 ? 3'b001 : 3'b000);
        end

        // same hold on unmasked channel 2: never repeats
        bus.button_n = 3'b011;
        wait_press(3'b100, "t4_press");
        for (int off = 1; off <= 30; off++) begin
            if (off == 21) bus.button_n = 3'b111;
            step();
            chk($sformatf("t4_rep_%0d", off), bus.repeated, 0);
            chk($sformatf("t4_pr_%0d", off), bus.pressed, 0);
            chk($sformatf("t4_act_%0d", off), bus.action, 0);
            chk($sformatf("t4_rel_%0d", off), bus.released, off == 26 ? 3'b100 : 3'b000);
            chk($sformatf("t4_held_%0d", off), bus.held, off < 26 ? 3'b100 : 3'b000);
        end

        // reset while channel 0 is repeating, button kept down
        bus.button_n = 3'b110;
        wait_press(3'b001, "t6_press");
        for (int off = 1; off <= 12; off++) begin
            step();
            chk($sformatf("t6_rep_%0d", off), bus.repeated,
                (off == 5 || off == 8 || off == 11) ? 3'b001 : 3'b000);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_rst_held", bus.held, 0);
        chk("t6_rst_pressed", bus.pressed, 0);
        chk("t6_rst_released", bus.released, 0);
        chk("t6_rst_repeated", bus.repeated, 0);
        chk("t6_rst_action", bus.action, 0);
        begin
            int n = 0;
            do begin
                step();
                n++;
            end while (bus.pressed == 3'b000 && n < 12);
            chk("t6_repress_latency", n, 6);
            chk("t6_repress_mask", bus.pressed, 3'b001);
        end
        for (int off = 1; off <= 8; off++) begin
            step();
            chk($sformatf("t6_rep2_%0d", off), bus.repeated, (off == 5 || off == 8) ? 3'b001 : 3'b000);
        end
        bus.button_n = 3'b111;
        for (int k = 0; k < 8; k++) step();
        chk("t6_final_held", bus.held, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
